// File: rtl/dcache_fill_ctrl.sv
// rtl/dcache_fill_ctrl.sv - dcache line miss handler: dirty victim write-back then line refill
module dcache_fill_ctrl #(
    parameter int DATABITS      = 32,
    parameter int ADDRBITS      = 32,
    parameter int CACHEADDRBITS = 5,
    parameter int LSBITS        = 2,
    parameter int MSBITS        = ADDRBITS - CACHEADDRBITS - LSBITS,
    parameter int CACHESIZE     = 2 ** CACHEADDRBITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     line_miss,
    input  logic                     line_dirty,
    input  logic [MSBITS-1:0]        line_victim_tag,
    input  logic [ADDRBITS-1:0]      line_mem_addr,
    input  logic [DATABITS-1:0]      line_out,
    input  logic                     dcache_wrreq,
    output logic                     flush_mode,
    output logic                     flush_write,
    output logic [CACHEADDRBITS-1:0] flush_addr,
    output logic                     flush_dirty,
    output logic [DATABITS-1:0]      line_in,
    output logic                     line_in_valid,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRBITS-1:0]      mem_addr_o,
    output logic [DATABITS-1:0]      mem_wdata,
    input  logic [DATABITS-1:0]      mem_rdata,
    input  logic                     mem_ack
);

    typedef enum logic [2:0] {IDLE, WB_RD, WB_REQ, FILL_REQ, FILL_GAP, DONE} state_t;

    state_t                   state, state_nxt;
    logic [CACHEADDRBITS-1:0] counter, counter_nxt;
    logic [MSBITS-1:0]        tag_new, tag_old;
    logic                     gap;
    logic                     req_state;
    logic                     ack;
    logic                     last_word;
    logic                     unused_addr_bits;

    assign unused_addr_bits = ^line_mem_addr[ADDRBITS-MSBITS-1:0];

    assign req_state = (state == WB_REQ) || (state == FILL_REQ);
    // gap forces one idle cycle after every completed transfer
    assign mem_req   = req_state && !gap;
    assign ack       = mem_req && mem_ack;
    assign last_word = (counter == CACHEADDRBITS'(CACHESIZE - 1));

    assign flush_mode    = (state != IDLE);
    assign flush_write   = (state == FILL_GAP);
    assign flush_addr    = counter;
    assign line_in_valid = (state == DONE);
    assign mem_we        = (state == WB_REQ);
    assign mem_addr_o    = req_state ? {(state == WB_REQ) ? tag_old : tag_new, counter, {LSBITS{1'b0}}}
                                     : '0;
    // flush_addr is held through WB_REQ, so the line keeps presenting the victim word
    assign mem_wdata     = (state == WB_REQ) ? line_out : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            counter     <= '0;
            tag_new     <= '0;
            tag_old     <= '0;
            gap         <= 1'b0;
            flush_dirty <= 1'b0;
            line_in     <= '0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
            gap     <= ack;
            if (state == IDLE && line_miss) begin
                tag_new     <= line_mem_addr[ADDRBITS-1:ADDRBITS-MSBITS];
                tag_old     <= line_victim_tag;
                flush_dirty <= dcache_wrreq;
            end
            if (state == DONE)
                flush_dirty <= 1'b0;
            if (state == FILL_REQ && ack)
                line_in <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        case (state)
            IDLE: begin
                if (line_miss) begin
                    counter_nxt = '0;
                    state_nxt   = line_dirty ? WB_RD : FILL_REQ;
                end
            end
            WB_RD: state_nxt = WB_REQ;
            WB_REQ: begin
                if (ack) begin
                    if (last_word) begin
                        counter_nxt = '0;
                        state_nxt   = FILL_REQ;
                    end else begin
                        counter_nxt = counter + 1'b1;
                        state_nxt   = WB_RD;
                    end
                end
            end
            FILL_REQ: begin
                if (ack)
                    state_nxt = FILL_GAP;
            end
            FILL_GAP: begin
                if (last_word) begin
                    state_nxt = DONE;
                end else begin
                    counter_nxt = counter + 1'b1;
                    state_nxt   = FILL_REQ;
                end
            end
            DONE: begin
                counter_nxt = '0;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_fill_ctrl.sv
// tb/tb_dcache_fill_ctrl.sv - directed self-checking bench for dcache_fill_ctrl
module tb_dcache_fill_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        line_miss, line_dirty, dcache_wrreq;
    logic [24:0] line_victim_tag;
    logic [31:0] line_mem_addr;
    logic [31:0] line_out = 32'h0;
    logic        flush_mode, flush_write, flush_dirty, line_in_valid;
    logic [4:0]  flush_addr;
    logic [31:0] line_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr_o, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    dcache_fill_ctrl dut (
        .clk(clk), .reset_n(reset_n), .line_miss(line_miss), .line_dirty(line_dirty),
        .line_victim_tag(line_victim_tag), .line_mem_addr(line_mem_addr), .line_out(line_out),
        .dcache_wrreq(dcache_wrreq), .flush_mode(flush_mode), .flush_write(flush_write),
        .flush_addr(flush_addr), .flush_dirty(flush_dirty), .line_in(line_in),
        .line_in_valid(line_in_valid), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_o(mem_addr_o), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // line model: synchronous read of the word at flush_addr
    always @(posedge clk) line_out <= 32'hA5A50000 + {27'h0, flush_addr};

    // memory model: ack arrives in the lat-th cycle of mem_req (lat=1 is zero-wait)
    int          lat = 1;
    bit          special = 1'b0;
    int          req_cnt = 0;
    logic [31:0] first_addr;
    logic        first_we;
    int          unstable = 0;
    int          gap_viol = 0;
    logic [31:0] ack_addr[$];
    logic        ack_we[$];
    logic [31:0] ack_wdata[$];

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return 32'hC0DE0000 | {16'h0, a[15:0]};
    endfunction

    always @(negedge clk) begin
        if (mem_req && mem_ack) gap_viol++;
        if (mem_req) begin
            req_cnt++;
            if (req_cnt == 1) begin
                first_addr = mem_addr_o;
                first_we   = mem_we;
            end else if (mem_addr_o !== first_addr || mem_we !== first_we) begin
                unstable++;
            end
            if (req_cnt == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = (special && mem_addr_o[6:2] == 5'd31) ? 32'hDEADBEEF : rd_word(mem_addr_o);
                ack_addr.push_back(mem_addr_o);
                ack_we.push_back(mem_we);
                ack_wdata.push_back(mem_wdata);
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            req_cnt = 0;
            mem_ack = 1'b0;
        end
    end

    logic [4:0]  fw_addr[$];
    logic [31:0] fw_data[$];
    int          liv_cnt = 0;
    int          liv_cyc = 0;
    int          fw31_cyc = 0;

    always @(negedge clk) begin
        if (flush_write) begin
            fw_addr.push_back(flush_addr);
            fw_data.push_back(line_in);
            if (flush_addr == 5'd31) fw31_cyc = cyc;
        end
        if (line_in_valid) begin
            liv_cnt++;
            liv_cyc = cyc;
        end
    end

    task automatic clear_logs();
        ack_addr.delete(); ack_we.delete(); ack_wdata.delete();
        fw_addr.delete(); fw_data.delete();
        liv_cnt = 0; unstable = 0; gap_viol = 0;
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [24:0] vtag, input logic dirty, input logic wr);
        @(negedge clk);
        line_miss = 1'b1; line_mem_addr = addr; line_victim_tag = vtag;
        line_dirty = dirty; dcache_wrreq = wr;
        @(negedge clk);
        line_miss = 1'b0; line_dirty = 1'b0; dcache_wrreq = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n, output bit timeout);
        n = 0;
        while (!line_in_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        timeout = !line_in_valid;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        tests_run++;
        if ({mem_req, mem_we, flush_mode, flush_write, flush_dirty, line_in_valid} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, flush_mode, flush_write, flush_dirty, line_in_valid});
        end
        tests_run++;
        if ({mem_addr_o, mem_wdata, line_in, flush_addr} !== 101'b0) begin
            tests_failed++;
            $display("FAIL reset_data: addr %h wdata %h line_in %h faddr %0d want all 0", mem_addr_o, mem_wdata, line_in, flush_addr);
        end
    endtask

    task automatic test_clean_miss();
        int n, bad;
        bit to;
        clear_logs(); lat = 1;
        do_miss(32'h0000_1234, 25'h0, 1'b0, 1'b0);
        wait_done(500, n, to);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL clean_timeout: line_in_valid not seen in 500 cycles"); end
        tests_run++;
        if (ack_addr.size() != 32) begin tests_failed++; $display("FAIL clean_count: got %0d requests want 32", ack_addr.size()); end
        bad = 0;
        foreach (ack_addr[i]) if (ack_addr[i] !== 32'h1200 + 32'(4 * i) || ack_we[i] !== 1'b0) bad++;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL clean_addrs: got %0d bad read addresses want 0", bad); end
        tests_run++;
        if (fw_addr.size() != 32) begin tests_failed++; $display("FAIL clean_fw_count: got %0d want 32", fw_addr.size()); end
        bad = 0;
        foreach (fw_addr[i]) if (fw_addr[i] !== 5'(i) || fw_data[i] !== rd_word(32'h1200 + 32'(4 * i))) bad++;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL clean_fw_data: got %0d bad refill words want 0", bad); end
        tests_run++;
        if (liv_cnt != 1) begin tests_failed++; $display("FAIL clean_valid: got %0d line_in_valid pulses want 1", liv_cnt); end
        tests_run++;
        if (flush_mode !== 1'b0) begin tests_failed++; $display("FAIL clean_release: flush_mode %b want 0", flush_mode); end
    endtask

    task automatic test_dirty_miss();
        int n, bad;
        bit to;
        clear_logs(); lat = 1;
        do_miss(32'h0000_9A00, 25'h0AC, 1'b1, 1'b0);
        wait_done(800, n, to);
        tests_run++;
        if (to || ack_addr.size() != 64) begin
            tests_failed++;
            $display("FAIL dirty_count: timeout %0d requests %0d want 0 and 64", to, ack_addr.size());
        end
        bad = 0;
        for (int i = 0; i < 32 && i < ack_addr.size(); i++)
            if (ack_addr[i] !== 32'h5600 + 32'(4 * i) || ack_we[i] !== 1'b1 || ack_wdata[i] !== 32'hA5A50000 + 32'(i)) bad++;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL dirty_writeback: got %0d bad writes want 0", bad); end
        bad = 0;
        for (int i = 32; i < ack_addr.size(); i++)
            if (ack_addr[i] !== 32'h9A00 + 32'(4 * (i - 32)) || ack_we[i] !== 1'b0) bad++;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL dirty_refill: got %0d bad reads want 0", bad); end
        tests_run++;
        if (gap_viol != 0) begin tests_failed++; $display("FAIL dirty_gap: got %0d back-to-back requests want 0", gap_viol); end
    endtask

    task automatic test_slow_memory();
        int n;
        bit to;
        clear_logs(); lat = 3;
        do_miss(32'h0000_1234, 25'h0, 1'b0, 1'b0);
        wait_done(1000, n, to);
        tests_run++;
        if (to || n + 1 < 128 || n + 1 > 130) begin
            tests_failed++;
            $display("FAIL slow_latency: got %0d cycles (timeout %0d) want 129 +-1", n + 1, to);
        end
        tests_run++;
        if (unstable != 0 || ack_addr.size() != 32) begin
            tests_failed++;
            $display("FAIL slow_stable: got %0d unstable cycles %0d requests want 0 and 32", unstable, ack_addr.size());
        end
        lat = 1;
    endtask

    task automatic test_write_miss();
        int n, bad, dirty_bad;
        clear_logs(); lat = 1;
        do_miss(32'h0000_3300, 25'h0, 1'b0, 1'b1);
        n = 0; dirty_bad = 0;
        while (!line_in_valid && n < 500) begin
            if (flush_mode && !flush_dirty) dirty_bad++;
            line_miss = (n == 20);
            line_dirty = (n == 20);
            if (n == 20) line_mem_addr = 32'h0000_7700;
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!line_in_valid) begin tests_failed++; $display("FAIL wr_timeout: line_in_valid not seen in 500 cycles"); end
        tests_run++;
        if (dirty_bad != 0 || flush_dirty !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_flush_dirty: got %0d low cycles, at done %b want 0 and 1", dirty_bad, flush_dirty);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (flush_dirty !== 1'b0) begin tests_failed++; $display("FAIL wr_dirty_clear: got %b want 0", flush_dirty); end
        bad = 0;
        foreach (ack_addr[i]) if (ack_addr[i] !== 32'h3300 + 32'(4 * i) || ack_we[i] !== 1'b0) bad++;
        tests_run++;
        if (bad != 0 || ack_addr.size() != 32 || liv_cnt != 1) begin
            tests_failed++;
            $display("FAIL wr_ignore_miss: got %0d bad %0d requests %0d valids want 0 32 1", bad, ack_addr.size(), liv_cnt);
        end
    endtask

    task automatic test_reset_mid_fill();
        int n;
        bit to;
        clear_logs(); lat = 1;
        do_miss(32'h0000_1234, 25'h0, 1'b0, 1'b1);
        n = 0;
        while (!(flush_write && flush_addr == 5'd10) && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= 200) begin tests_failed++; $display("FAIL rst_reach: word 10 never written"); end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({mem_req, mem_we, flush_mode, flush_write, flush_dirty, line_in_valid} !== 6'b0 || mem_addr_o !== 32'h0 || line_in !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_async: ctrl %b addr %h line_in %h want 0", {mem_req, mem_we, flush_mode, flush_write, flush_dirty, line_in_valid}, mem_addr_o, line_in);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        tests_run++;
        if (liv_cnt != 0 || flush_mode !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_no_valid: got %0d valids flush_mode %b want 0 0", liv_cnt, flush_mode);
        end
        clear_logs();
        do_miss(32'h0000_1234, 25'h0, 1'b0, 1'b0);
        wait_done(500, n, to);
        tests_run++;
        if (to || ack_addr.size() != 32 || ack_addr[0] !== 32'h1200 || fw_addr[0] !== 5'd0) begin
            tests_failed++;
            $display("FAIL rst_restart: timeout %0d requests %0d first addr %h want 0 32 00001200", to, ack_addr.size(), (ack_addr.size() > 0) ? ack_addr[0] : 32'hx);
        end
    endtask

    task automatic test_last_word();
        int n;
        bit to;
        clear_logs(); lat = 1; special = 1'b1;
        do_miss(32'h0000_4480, 25'h0, 1'b0, 1'b0);
        wait_done(500, n, to);
        tests_run++;
        if (to || fw_data.size() != 32 || fw_addr[31] !== 5'd31 || fw_data[31] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL last_word: timeout %0d writes %0d data %h want 0 32 deadbeef", to, fw_data.size(), (fw_data.size() == 32) ? fw_data[31] : 32'hx);
        end
        tests_run++;
        if (liv_cyc != fw31_cyc + 1) begin
            tests_failed++;
            $display("FAIL last_valid: line_in_valid at cycle %0d want %0d", liv_cyc, fw31_cyc + 1);
        end
        special = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; line_miss = 1'b0; line_dirty = 1'b0; dcache_wrreq = 1'b0;
        line_victim_tag = '0; line_mem_addr = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_slow_memory();
        test_write_miss();
        test_reset_mid_fill();
        test_last_word();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
